// File: rtl/global_buffer_sequencer.sv
// Instruction-driven global buffer: one single-port SRAM split into
// weight / activation / output regions, each with a persistent pointer.

package global_buffer_pkg;

    typedef enum logic [3:0] {
        I_NOP             = 4'd0,
        I_POINTER_RESET   = 4'd1,
        I_LOAD_WEIGHT     = 4'd2,
        I_LOAD_ACTIVATION = 4'd3,
        I_LOAD_OUTPUT     = 4'd4,
        I_READ_ACTIVATION = 4'd5
    } global_buffer_instruction_t;

endpackage

module global_buffer_sequencer
    import global_buffer_pkg::*;
#(
    parameter int dataSize       = 8,
    parameter int interfaceDepth = 16,
    parameter int addrWidth      = 10,
    parameter int lenWidth       = addrWidth + 1
) (
    input  logic                                 clk,
    input  logic                                 nrst,
    input  logic [3:0]                           instr_i,
    input  logic                                 instr_valid_i,
    output logic                                 instr_ready_o,
    input  logic [lenWidth-1:0]                  xfer_len_i,
    input  logic [addrWidth-1:0]                 weight_start_addr_i,
    input  logic [addrWidth-1:0]                 activation_start_addr_i,
    input  logic [addrWidth-1:0]                 output_start_addr_i,
    input  logic [interfaceDepth*dataSize-1:0]   wr_data_i,
    input  logic                                 wr_en_i,
    output logic                                 wr_ready_o,
    output logic [interfaceDepth*dataSize-1:0]   rd_data_o,
    output logic                                 rd_data_valid_o,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 err_o
);

    localparam int interfaceWidth = interfaceDepth * dataSize;
    localparam int bufferDepth    = 2 ** addrWidth;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_READ,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        SEL_W,
        SEL_A,
        SEL_O
    } sel_t;

    state_t                    state_q, state_d;
    sel_t                      sel_q, sel_d;
    logic [addrWidth-1:0]      wptr_q, wptr_d;
    logic [addrWidth-1:0]      aptr_q, aptr_d;
    logic [addrWidth-1:0]      optr_q, optr_d;
    logic [lenWidth-1:0]       cnt_q, cnt_d;
    logic                      err_q, err_d;
    logic [interfaceWidth-1:0] rd_data_q;
    logic                      rd_valid_q;

    logic [interfaceWidth-1:0] mem_q [bufferDepth];

    logic [addrWidth-1:0]      cur_ptr;
    logic [addrWidth-1:0]      ptr_inc;
    logic                      adv;
    logic                      mem_we;
    logic                      rd_issue;

    // Pointer of the region the running transfer walks through.
    always_comb begin
        unique case (sel_q)
            SEL_A:   cur_ptr = aptr_q;
            SEL_O:   cur_ptr = optr_q;
            default: cur_ptr = wptr_q;
        endcase
    end

    assign ptr_inc = cur_ptr + addrWidth'(1);

    // Next-state, decode and pointer/counter update.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        wptr_d   = wptr_q;
        aptr_d   = aptr_q;
        optr_d   = optr_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        adv      = 1'b0;
        mem_we   = 1'b0;
        rd_issue = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (instr_valid_i) begin
                    unique case (instr_i)
                        I_NOP: begin
                            state_d = S_DONE;
                        end
                        I_POINTER_RESET: begin
                            wptr_d  = weight_start_addr_i;
                            aptr_d  = activation_start_addr_i;
                            optr_d  = output_start_addr_i;
                            state_d = S_DONE;
                        end
                        I_LOAD_WEIGHT,
                        I_LOAD_ACTIVATION,
                        I_LOAD_OUTPUT: begin
                            unique case (instr_i)
                                I_LOAD_WEIGHT:     sel_d = SEL_W;
                                I_LOAD_ACTIVATION: sel_d = SEL_A;
                                default:           sel_d = SEL_O;
                            endcase
                            cnt_d   = xfer_len_i;
                            state_d = (xfer_len_i == '0) ? S_DONE : S_LOAD;
                        end
                        I_READ_ACTIVATION: begin
                            sel_d   = SEL_A;
                            cnt_d   = xfer_len_i;
                            state_d = (xfer_len_i == '0) ? S_DONE : S_READ;
                        end
                        default: begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end
                    endcase
                end
            end
            S_LOAD: begin
                if (wr_en_i) begin
                    mem_we = 1'b1;
                    adv    = 1'b1;
                end
            end
            S_READ: begin
                rd_issue = 1'b1;
                adv      = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (adv) begin
            cnt_d = cnt_q - lenWidth'(1);
            if (cnt_q == lenWidth'(1)) begin
                state_d = S_DONE;
            end
            unique case (sel_q)
                SEL_A:   aptr_d = ptr_inc;
                SEL_O:   optr_d = ptr_inc;
                default: wptr_d = ptr_inc;
            endcase
        end
    end

    // Control state, pointers, counter and error pulse.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            sel_q   <= SEL_W;
            wptr_q  <= '0;
            aptr_q  <= '0;
            optr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            wptr_q  <= wptr_d;
            aptr_q  <= aptr_d;
            optr_q  <= optr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // SRAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[cur_ptr] <= wr_data_i;
        end
    end

    // Registered read data; holds when no read is issued.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_issue;
            if (rd_issue) begin
                rd_data_q <= mem_q[cur_ptr];
            end
        end
    end

    assign instr_ready_o   = nrst & (state_q == S_IDLE);
    assign wr_ready_o      = (state_q == S_LOAD);
    assign busy_o          = (state_q != S_IDLE);
    assign done_o          = (state_q == S_DONE);
    assign err_o           = err_q;
    assign rd_data_o       = rd_data_q;
    assign rd_data_valid_o = rd_valid_q;

endmodule

// File: tb/tb_global_buffer_sequencer.sv
// Bench for global_buffer_sequencer: directed scenarios plus random
// instruction streams, checked against a queue-based buffer model.

module tb_global_buffer_sequencer;

    localparam int AW    = 10;
    localparam int LW    = 11;
    localparam int DW    = 128;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          nrst = 1'b1;
    logic [3:0]    instr_i = '0;
    logic          instr_valid_i = 1'b0;
    logic          instr_ready_o;
    logic [LW-1:0] xfer_len_i = '0;
    logic [AW-1:0] st_w = '0;
    logic [AW-1:0] st_a = '0;
    logic [AW-1:0] st_o = '0;
    logic [DW-1:0] wr_data_i = '0;
    logic          wr_en_i = 1'b0;
    logic          wr_ready_o;
    logic [DW-1:0] rd_data_o;
    logic          rd_data_valid_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mdl [DEPTH];
    int wp = 0;
    int ap = 0;
    int opp = 0;

    typedef struct {
        logic [DW-1:0] d;
        bit            last;
    } rd_t;

    rd_t rd_q[$];
    bit  ev_q[$];

    global_buffer_sequencer dut (
        .clk                     (clk),
        .nrst                    (nrst),
        .instr_i                 (instr_i),
        .instr_valid_i           (instr_valid_i),
        .instr_ready_o           (instr_ready_o),
        .xfer_len_i              (xfer_len_i),
        .weight_start_addr_i     (st_w),
        .activation_start_addr_i (st_a),
        .output_start_addr_i     (st_o),
        .wr_data_i               (wr_data_i),
        .wr_en_i                 (wr_en_i),
        .wr_ready_o              (wr_ready_o),
        .rd_data_o               (rd_data_o),
        .rd_data_valid_o         (rd_data_valid_o),
        .busy_o                  (busy_o),
        .done_o                  (done_o),
        .err_o                   (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [DW-1:0] a,
                       input logic [DW-1:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
        end
    endtask

    task automatic chk1(input string n, input logic a, input logic e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%b want=%b t=%0t", n, a, e, $time);
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: read data, done/err pairing, hold of read data.
    initial begin
        rd_t           e;
        bit            eb;
        logic [DW-1:0] last_rd;
        last_rd = '0;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                last_rd = '0;
            end else begin
                if (rd_data_valid_o) begin
                    if (rd_q.size() == 0) begin
                        chk1("rd_spurious", rd_data_valid_o, 1'b0);
                    end else begin
                        e = rd_q.pop_front();
                        chk("rd_data", rd_data_o, e.d);
                        chk1("rd_last_done", done_o, e.last);
                    end
                    last_rd = rd_data_o;
                end else begin
                    chk("rd_hold", rd_data_o, last_rd);
                end
                if (done_o) begin
                    if (ev_q.size() == 0) begin
                        chk1("done_spurious", done_o, 1'b0);
                    end else begin
                        eb = ev_q.pop_front();
                        chk1("err_with_done", err_o, eb);
                    end
                end else begin
                    chk1("err_without_done", err_o, 1'b0);
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!instr_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk1("instr_ready", instr_ready_o, 1'b1);
    endtask

    // Issue one instruction, update the model, drive its data phase.
    task automatic run(input logic [3:0] op, input int len,
                       input int gmin, input int gmax);
        int            p;
        logic [DW-1:0] d;
        wait_ready();
        instr_i       = op;
        xfer_len_i    = LW'(len);
        instr_valid_i = 1'b1;
        ev_q.push_back(op > 4'd5);
        if (op == 4'd1) begin
            wp  = int'(st_w);
            ap  = int'(st_a);
            opp = int'(st_o);
        end
        if (op == 4'd5) begin
            for (int i = 0; i < len; i++) begin
                rd_q.push_back('{mdl[ap], i == len - 1});
                ap = (ap + 1) % DEPTH;
            end
        end
        @(negedge clk);
        instr_valid_i = 1'b0;
        if (len == 0 || op < 4'd2 || op > 4'd5) begin
            chk1("done_t1", done_o, 1'b1);
            chk1("busy_t1", busy_o, 1'b1);
            chk1("wr_ready_off", wr_ready_o, 1'b0);
        end else if (op == 4'd5) begin
            repeat (len) @(negedge clk);
            chk1("read_done", done_o, 1'b1);
        end else begin
            p = (op == 4'd2) ? wp : (op == 4'd3) ? ap : opp;
            for (int i = 0; i < len; i++) begin
                d         = rnd();
                wr_data_i = d;
                wr_en_i   = 1'b1;
                chk1("wr_ready", wr_ready_o, 1'b1);
                mdl[p] = d;
                p = (p + 1) % DEPTH;
                @(negedge clk);
                wr_en_i   = 1'b0;
                wr_data_i = rnd();
                if (i < len - 1) begin
                    repeat ($urandom_range(gmax, gmin)) @(negedge clk);
                end
            end
            chk1("load_done", done_o, 1'b1);
            if (op == 4'd2) wp = p;
            else if (op == 4'd3) ap = p;
            else opp = p;
        end
    endtask

    task automatic ptr_reset(input int w, input int a, input int o);
        st_w = AW'(w);
        st_a = AW'(a);
        st_o = AW'(o);
        run(4'd1, 0, 0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        int ln;
        #1 nrst = 1'b0;
        #2;
        chk1("rst_instr_ready", instr_ready_o, 1'b0);
        chk1("rst_busy", busy_o, 1'b0);
        chk1("rst_done", done_o, 1'b0);
        chk1("rst_err", err_o, 1'b0);
        chk1("rst_rd_valid", rd_data_valid_o, 1'b0);
        chk1("rst_wr_ready", wr_ready_o, 1'b0);
        chk("rst_rd_data", rd_data_o, '0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        chk1("ready_after_rst", instr_ready_o, 1'b1);

        ptr_reset(12'h000, 12'h100, 12'h200);
        @(negedge clk);
        chk1("busy_one_cycle", busy_o, 1'b0);

        ptr_reset(0, 0, 0);
        run(4'd2, DEPTH, 0, 0);

        ptr_reset(12'h000, 12'h100, 12'h200);
        run(4'd3, 4, 1, 1);
        ptr_reset(12'h000, 12'h100, 12'h200);
        run(4'd5, 4, 0, 0);

        ptr_reset(12'h000, 12'h3FE, 12'h200);
        run(4'd3, 4, 0, 2);
        ptr_reset(12'h000, 12'h3FE, 12'h200);
        run(4'd5, 4, 0, 0);

        ptr_reset(12'h050, 12'h050, 12'h200);
        run(4'd2, 2, 0, 1);
        run(4'd7, 0, 0, 0);
        run(4'd2, 2, 0, 1);
        ptr_reset(12'h050, 12'h050, 12'h200);
        run(4'd5, 4, 0, 0);

        ptr_reset(12'h000, 12'h060, 12'h200);
        run(4'd3, 2, 0, 0);
        ptr_reset(12'h000, 12'h060, 12'h200);
        wr_en_i   = 1'b1;
        wr_data_i = rnd();
        run(4'd3, 0, 0, 0);
        @(negedge clk);
        chk1("len0_no_wr_ready", wr_ready_o, 1'b0);
        wr_en_i = 1'b0;
        run(4'd5, 2, 0, 0);

        ptr_reset(12'h000, 12'h100, 12'h200);
        wait_ready();
        instr_i       = 4'd5;
        xfer_len_i    = LW'(8);
        instr_valid_i = 1'b1;
        rd_q.push_back('{mdl[ap], 1'b0});
        @(negedge clk);
        instr_valid_i = 1'b0;
        @(negedge clk);
        chk1("rd_valid_pre_rst", rd_data_valid_o, 1'b1);
        #2 nrst = 1'b0;
        rd_q.delete();
        ev_q.delete();
        #1;
        chk1("abort_rd_valid", rd_data_valid_o, 1'b0);
        chk("abort_rd_data", rd_data_o, '0);
        chk1("abort_busy", busy_o, 1'b0);
        chk1("abort_done", done_o, 1'b0);
        chk1("abort_ready", instr_ready_o, 1'b0);
        wp = 0;
        ap = 0;
        opp = 0;
        repeat (2) @(negedge clk);
        chk1("abort_no_done", done_o, 1'b0);
        nrst = 1'b1;
        run(4'd0, 0, 0, 0);

        for (int k = 0; k < 60; k++) begin
            r  = int'($urandom_range(0, 19));
            ln = int'($urandom_range(0, 6));
            if (r < 3) begin
                ptr_reset(int'($urandom_range(0, DEPTH - 1)),
                          int'($urandom_range(0, DEPTH - 1)),
                          int'($urandom_range(0, DEPTH - 1)));
            end else if (r < 5) begin
                run(4'd0, ln, 0, 0);
            end else if (r < 11) begin
                run(4'($urandom_range(2, 4)), ln, 0, 2);
            end else if (r < 17) begin
                run(4'd5, ln, 0, 0);
            end else begin
                run(4'($urandom_range(6, 15)), ln, 0, 0);
            end
        end

        repeat (4) @(negedge clk);
        chk1("rd_queue_drained", rd_q.size() == 0, 1'b1);
        chk1("ev_queue_drained", ev_q.size() == 0, 1'b1);
        chk1("final_idle", busy_o, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
